// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the multi-lane AD5791-class SPI DAC driver.
// The frame FSM states, the DAC command codes and the default frame geometry.
package dac_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [3:0] CMD_WR_DAC  = 4'b0001;
    localparam logic [3:0] CMD_WR_CTRL = 4'b0010;

    localparam int DEF_FRAME_BITS = 24;
    localparam int DEF_DATA_BITS  = 20;

endpackage

// File: rtl/dac_spi_lane.sv
// One SPI data lane: a FRAME_BITS shift register loaded in parallel, shifted MSB first.
// Load and shift strobes come from the shared timing FSM in the top module.
module dac_spi_lane #(
    parameter int FRAME_BITS = 24
) (
    input  logic                  a_clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  shift,
    input  logic [FRAME_BITS-1:0] word,
    output logic                  msb
);

    logic [FRAME_BITS-1:0] shreg;

    always_ff @(posedge a_clk) begin
        if (reset) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= word;
        end else if (shift) begin
            shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
        end
    end

    assign msb = shreg[FRAME_BITS-1];

endmodule

// File: rtl/axis_dac_spi_multi.sv
// N-lane serial DAC driver: streams AXIS setpoints or per-axis config words to
// parallel SPI lanes sharing SCLK/SYNC, suppressing frames with unchanged data.
module axis_dac_spi_multi
    import dac_spi_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int SCLK_HALF  = 2,
    parameter int SYNC_GAP   = 4,
    parameter int AXIS_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  a_clk,
    input  logic                  reset,
    input  logic [32*NUM_CH-1:0]  S_AXIS_tdata,
    input  logic [NUM_CH-1:0]     S_AXIS_tvalid,
    input  logic [31:0]           S_AXISCFG_tdata,
    input  logic                  S_AXISCFG_tvalid,
    input  logic                  configuration_mode,
    input  logic [AXIS_W-1:0]     configuration_axis,
    input  logic                  configuration_send,
    output logic                  dac_sclk,
    output logic                  dac_sync_n,
    output logic [NUM_CH-1:0]     dac_sdo,
    output logic                  busy,
    output logic [31:0]           frames_sent
);

    localparam int CMD_W = FRAME_BITS - DATA_BITS;
    localparam int DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int BIT_W = $clog2(FRAME_BITS + 1);
    localparam int GAP_W = $clog2(SYNC_GAP + 1);
    localparam logic [CMD_W-1:0] CMD_STREAM = CMD_W'(CMD_WR_DAC);

    state_t                 state, state_nxt;
    logic [DIV_W-1:0]       div_cnt;
    logic                   sclk_q;
    logic [BIT_W-1:0]       bit_cnt;
    logic [GAP_W-1:0]       gap_cnt;
    logic [31:0]            frame_cnt;

    logic [DATA_BITS-1:0]   code      [NUM_CH];
    logic [DATA_BITS-1:0]   latch     [NUM_CH];
    logic [DATA_BITS-1:0]   sent      [NUM_CH];
    logic [FRAME_BITS-1:0]  cfg       [NUM_CH];
    logic [FRAME_BITS-1:0]  lane_word [NUM_CH];
    logic [NUM_CH-1:0]      pending;
    logic [NUM_CH-1:0]      lane_msb;
    logic                   cfg_req;
    logic                   send_q;

    logic half_done, sclk_rise, sclk_fall, last_fall, gap_done, send_edge;
    logic start_cfg, start_stream, lane_load, lane_shift, frame_active;
    logic unused_bits;

    assign half_done = (div_cnt == DIV_W'(SCLK_HALF - 1));
    assign sclk_rise = (state == ST_SHIFT) && half_done && !sclk_q;
    assign sclk_fall = (state == ST_SHIFT) && half_done && sclk_q;
    assign last_fall = sclk_fall && (bit_cnt == BIT_W'(FRAME_BITS - 1));
    assign gap_done  = (gap_cnt == GAP_W'(SYNC_GAP - 1));
    assign send_edge = configuration_send && !send_q;

    // The MSB is already on the lane from LOAD, so the first SCLK rise must not
    // shift; every later rise advances one bit ahead of the DAC's falling-edge sample.
    assign lane_load  = start_cfg || start_stream;
    assign lane_shift = sclk_rise && (bit_cnt != '0);

    always_ff @(posedge a_clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt    = state;
        start_cfg    = 1'b0;
        start_stream = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cfg_req) begin
                    start_cfg = 1'b1;
                    state_nxt = ST_LOAD;
                end else if (!configuration_mode && (pending != '0)) begin
                    start_stream = 1'b1;
                    state_nxt    = ST_LOAD;
                end
            end
            ST_LOAD:  state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_fall) state_nxt = ST_GAP;
            ST_GAP:   if (gap_done)  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // SCLK divider, bit counter, SYNC gap timer and completed-frame counter.
    always_ff @(posedge a_clk) begin
        if (reset) begin
            div_cnt   <= '0;
            sclk_q    <= 1'b0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            if (state != ST_SHIFT) begin
                div_cnt <= '0;
                sclk_q  <= 1'b0;
                bit_cnt <= '0;
            end else begin
                div_cnt <= half_done ? '0 : div_cnt + 1'b1;
                if (half_done) sclk_q <= !sclk_q;
                if (sclk_fall) bit_cnt <= bit_cnt + 1'b1;
            end
            gap_cnt <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
            if (last_fall) frame_cnt <= frame_cnt + 32'd1;
        end
    end

    always_ff @(posedge a_clk) begin
        if (reset) begin
            // NOTE: the per-lane arrays are only NUM_CH registers each, so they are
            // reset explicitly and a fresh start never replays stale codes.
            for (int k = 0; k < NUM_CH; k++) begin
                latch[k] <= '0;
                sent[k]  <= '0;
                cfg[k]   <= '0;
            end
            pending <= '0;
            cfg_req <= 1'b0;
            send_q  <= 1'b0;
        end else begin
            send_q <= configuration_send;
            if (send_edge && configuration_mode) begin
                cfg_req <= 1'b1;
            end else if (start_cfg) begin
                cfg_req <= 1'b0;
            end

            for (int k = 0; k < NUM_CH; k++) begin
                if (S_AXIS_tvalid[k]) latch[k] <= code[k];
                // A sample arriving in the launch cycle survives only if it differs
                // from the code being loaded into the frame.
                if (start_stream) begin
                    sent[k]    <= latch[k];
                    pending[k] <= S_AXIS_tvalid[k] && (code[k] != latch[k]);
                end else if (S_AXIS_tvalid[k] && (code[k] != sent[k])) begin
                    pending[k] <= 1'b1;
                end
                if (configuration_mode && S_AXISCFG_tvalid &&
                    (configuration_axis == AXIS_W'(k))) begin
                    cfg[k] <= S_AXISCFG_tdata[FRAME_BITS-1:0];
                end
            end
        end
    end

    assign frame_active = (state == ST_LOAD) || (state == ST_SHIFT);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        assign code[k]      = S_AXIS_tdata[32*k+31 -: DATA_BITS];
        assign lane_word[k] = start_cfg ? cfg[k] : {CMD_STREAM, latch[k]};

        dac_spi_lane #(
            .FRAME_BITS (FRAME_BITS)
        ) u_lane (
            .a_clk (a_clk),
            .reset (reset),
            .load  (lane_load),
            .shift (lane_shift),
            .word  (lane_word[k]),
            .msb   (lane_msb[k])
        );

        assign dac_sdo[k] = frame_active && lane_msb[k];
    end

    assign dac_sclk    = sclk_q;
    assign dac_sync_n  = !frame_active;
    assign busy        = (state != ST_IDLE);
    assign frames_sent = frame_cnt;
    assign unused_bits = ^{S_AXIS_tdata, S_AXISCFG_tdata};

endmodule

// File: tb/tb_axis_dac_spi_multi.sv
// Scoreboard bench: stimulus pushes expected SPI frames from a behavioural model,
// monitors reassemble frames from the SPI pins and compare them.
module tb_axis_dac_spi_multi;

    localparam int NA    = 4;
    localparam int NB    = 8;
    localparam int FB    = 24;
    localparam int DB    = 20;
    localparam int GAP   = 4;
    localparam int LOW_A = 1 + 2 * 2 * FB;
    localparam int LOW_B = 1 + 2 * 1 * FB;

    logic a_clk = 1'b0;
    logic reset = 1'b1;

    logic [32*NA-1:0] a_tdata;
    logic [NA-1:0]    a_tvalid;
    logic [31:0]      cfg_tdata;
    logic             cfg_tvalid, cfg_mode, cfg_send;
    logic [1:0]       cfg_axis;
    logic             a_sclk, a_sync_n, a_busy;
    logic [NA-1:0]    a_sdo;
    logic [31:0]      a_frames;

    logic [32*NB-1:0] b_tdata;
    logic [NB-1:0]    b_tvalid;
    logic [31:0]      b_cfg_tdata;
    logic             b_cfg_tvalid, b_cfg_mode, b_cfg_send;
    logic [2:0]       b_cfg_axis;
    logic             b_sclk, b_sync_n, b_busy;
    logic [NB-1:0]    b_sdo;
    logic [31:0]      b_frames;

    axis_dac_spi_multi dut_a (
        .a_clk              (a_clk),
        .reset              (reset),
        .S_AXIS_tdata       (a_tdata),
        .S_AXIS_tvalid      (a_tvalid),
        .S_AXISCFG_tdata    (cfg_tdata),
        .S_AXISCFG_tvalid   (cfg_tvalid),
        .configuration_mode (cfg_mode),
        .configuration_axis (cfg_axis),
        .configuration_send (cfg_send),
        .dac_sclk           (a_sclk),
        .dac_sync_n         (a_sync_n),
        .dac_sdo            (a_sdo),
        .busy               (a_busy),
        .frames_sent        (a_frames)
    );

    axis_dac_spi_multi #(.NUM_CH(NB), .SCLK_HALF(1)) dut_b (
        .a_clk              (a_clk),
        .reset              (reset),
        .S_AXIS_tdata       (b_tdata),
        .S_AXIS_tvalid      (b_tvalid),
        .S_AXISCFG_tdata    (b_cfg_tdata),
        .S_AXISCFG_tvalid   (b_cfg_tvalid),
        .configuration_mode (b_cfg_mode),
        .configuration_axis (b_cfg_axis),
        .configuration_send (b_cfg_send),
        .dac_sclk           (b_sclk),
        .dac_sync_n         (b_sync_n),
        .dac_sdo            (b_sdo),
        .busy               (b_busy),
        .frames_sent        (b_frames)
    );

    always #5 a_clk = ~a_clk;

    int cyc = 0;
    always @(posedge a_clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: latest code per lane, last code sent, config words, mode.
    logic [DB-1:0]    m_latch [NA];
    logic [DB-1:0]    m_sent  [NA];
    logic [FB-1:0]    m_cfg   [NA];
    logic [NA-1:0]    m_pending;
    logic             m_mode;
    logic [NA*FB-1:0] exp_q  [$];
    logic [NB*FB-1:0] exp_qb [$];

    int   last_drive_cyc = 0;
    logic lat_check = 1'b0;
    logic check_gap = 1'b0;

    function automatic logic [NA*FB-1:0] stream_frame();
        logic [NA*FB-1:0] f;
        for (int k = 0; k < NA; k++) f[k*FB +: FB] = {4'b0001, m_latch[k]};
        return f;
    endfunction

    function automatic logic [NA*FB-1:0] cfg_frame();
        logic [NA*FB-1:0] f;
        for (int k = 0; k < NA; k++) f[k*FB +: FB] = m_cfg[k];
        return f;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NA; k++) begin
            m_latch[k] = '0;
            m_sent[k]  = '0;
            m_cfg[k]   = '0;
        end
        m_pending = '0;
        exp_q.delete();
    endtask

    task automatic launch_if_pending();
        if (!m_mode && m_pending != '0) begin
            exp_q.push_back(stream_frame());
            for (int k = 0; k < NA; k++) m_sent[k] = m_latch[k];
            m_pending = '0;
        end
    endtask

    task automatic drive_stream(input logic [NA-1:0] mask, input logic [DB-1:0] codes [NA]);
        @(posedge a_clk); #1;
        for (int k = 0; k < NA; k++) begin
            a_tdata[32*k +: 32] = {codes[k], 12'($urandom)};
            if (mask[k]) begin
                if (codes[k] != m_sent[k]) m_pending[k] = 1'b1;
                m_latch[k] = codes[k];
            end
        end
        a_tvalid = mask;
        last_drive_cyc = cyc;
        launch_if_pending();
        @(posedge a_clk); #1;
        a_tvalid = '0;
    endtask

    task automatic write_cfg(input int axis, input logic [31:0] word);
        @(posedge a_clk); #1;
        cfg_axis   = axis[1:0];
        cfg_tdata  = word;
        cfg_tvalid = 1'b1;
        if (m_mode) m_cfg[axis] = word[FB-1:0];
        @(posedge a_clk); #1;
        cfg_tvalid = 1'b0;
    endtask

    task automatic pulse_send();
        @(posedge a_clk); #1;
        cfg_send = 1'b1;
        if (m_mode) exp_q.push_back(cfg_frame());
        repeat (3) @(posedge a_clk);
        #1;
        cfg_send = 1'b0;
    endtask

    task automatic set_mode(input logic m);
        @(posedge a_clk); #1;
        cfg_mode = m;
        m_mode   = m;
        launch_if_pending();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        int stable = 0;
        while (stable < 4 && n < 2000) begin
            @(negedge a_clk);
            stable = a_busy ? 0 : stable + 1;
            n++;
        end
        check(name, stable >= 4, 1'b1);
    endtask

    // Monitor for the 4-lane instance.
    logic             a_ps = 1'b1, a_pc = 1'b0;
    int               a_fall_cyc = 0, a_rise_cyc = -1000, a_nbits = 0, a_exp_frames = 0;
    int               falls_in_reset = 0;
    logic [FB-1:0]    a_acc [NA];
    logic [NA*FB-1:0] a_got;

    always @(negedge a_clk) begin
        if (a_ps && !a_sync_n) begin
            if (reset) falls_in_reset++;
            a_fall_cyc = cyc;
            a_nbits    = 0;
            if (lat_check) begin
                check("stream_latency", cyc - last_drive_cyc, 2);
                lat_check = 1'b0;
            end
            if (check_gap) begin
                check("b2b_sync_gap", cyc - a_rise_cyc, GAP + 1);
                check_gap = 1'b0;
            end
        end
        if (!a_sync_n && !a_pc && a_sclk) begin
            for (int k = 0; k < NA; k++) a_acc[k] = {a_acc[k][FB-2:0], a_sdo[k]};
            a_nbits++;
        end
        if (!a_ps && a_sync_n && !reset) begin
            check("sync_low_cycles", cyc - a_fall_cyc, LOW_A);
            check("sclk_rises", a_nbits, FB);
            a_exp_frames++;
            check("frames_sent", a_frames, a_exp_frames);
            check("frame_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                for (int k = 0; k < NA; k++) a_got[k*FB +: FB] = a_acc[k];
                check("frame_lanes", a_got, exp_q.pop_front());
            end
            a_rise_cyc = cyc;
        end
        if (reset) a_exp_frames = 0;
        a_ps = a_sync_n;
        a_pc = a_sclk;
    end

    // Monitor for the 8-lane, SCLK_HALF=1 instance.
    logic             b_ps = 1'b1, b_pc = 1'b0;
    int               b_fall_cyc = 0, b_nbits = 0;
    logic [FB-1:0]    b_acc [NB];
    logic [NB*FB-1:0] b_got;

    always @(negedge a_clk) begin
        if (b_ps && !b_sync_n) begin
            b_fall_cyc = cyc;
            b_nbits    = 0;
        end
        if (!b_sync_n && !b_pc && b_sclk) begin
            for (int k = 0; k < NB; k++) b_acc[k] = {b_acc[k][FB-2:0], b_sdo[k]};
            b_nbits++;
        end
        if (!b_ps && b_sync_n && !reset) begin
            check("b_sync_low_cycles", cyc - b_fall_cyc, LOW_B);
            check("b_sclk_rises", b_nbits, FB);
            check("b_frame_expected", exp_qb.size() != 0, 1'b1);
            if (exp_qb.size() != 0) begin
                for (int k = 0; k < NB; k++) b_got[k*FB +: FB] = b_acc[k];
                check("b_frame_lanes", b_got, exp_qb.pop_front());
            end
        end
        b_ps = b_sync_n;
        b_pc = b_sclk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DB-1:0]    c [NA];
        logic [NB*FB-1:0] bf;
        int               fb, nf, n;
        logic             ps;

        a_tdata = '0; a_tvalid = '0; cfg_tdata = '0; cfg_tvalid = 1'b0;
        cfg_mode = 1'b0; cfg_send = 1'b0; cfg_axis = '0;
        b_tdata = '0; b_tvalid = '0; b_cfg_tdata = '0; b_cfg_tvalid = 1'b0;
        b_cfg_mode = 1'b0; b_cfg_send = 1'b0; b_cfg_axis = '0;
        m_mode = 1'b0;
        model_reset();
        for (int k = 0; k < NA; k++) c[k] = '0;

        // Reset held while every input toggles.
        for (int i = 0; i < 8; i++) begin
            @(posedge a_clk); #1;
            a_tdata    = {$urandom, $urandom, $urandom, $urandom};
            a_tvalid   = NA'($urandom);
            cfg_tdata  = $urandom;
            cfg_tvalid = 1'($urandom);
            cfg_mode   = 1'($urandom);
            cfg_send   = 1'($urandom);
            b_tvalid   = NB'($urandom);
            b_tdata    = {8{$urandom}};
        end
        @(negedge a_clk);
        check("rst_sync_n", a_sync_n, 1'b1);
        check("rst_sclk", a_sclk, 1'b0);
        check("rst_sdo", a_sdo, '0);
        check("rst_busy", a_busy, 1'b0);
        check("rst_frames", a_frames, 32'd0);
        check("rst_b_sync_n", b_sync_n, 1'b1);
        @(posedge a_clk); #1;
        a_tvalid = '0; cfg_tvalid = 1'b0; cfg_mode = 1'b0; cfg_send = 1'b0; b_tvalid = '0;
        reset = 1'b0;
        check("no_sync_fall_in_reset", falls_in_reset, 0);

        // Directed stream: code 1 on lane 0, then the same code again.
        c[0] = 20'h00001;
        lat_check = 1'b1;
        drive_stream(4'b0001, c);
        wait_idle("idle_after_first");
        check("frames_after_first", a_frames, 32'd1);
        fb = a_frames;
        drive_stream(4'b0001, c);
        wait_idle("idle_after_repeat");
        check("repeat_suppressed", a_frames, fb);

        // Randomised streaming, some lanes repeating their last sent code.
        for (int r = 0; r < 16; r++) begin
            for (int k = 0; k < NA; k++)
                c[k] = ($urandom_range(0, 3) == 0) ? m_sent[k] : DB'($urandom);
            drive_stream(NA'($urandom), c);
            wait_idle("idle_random");
        end

        // Configuration frames; streams held back while in configuration mode.
        set_mode(1'b1);
        write_cfg(3, 32'h80);
        write_cfg(2, 32'h40);
        write_cfg(1, 32'h20);
        write_cfg(0, 32'h10);
        for (int k = 0; k < NA; k++) c[k] = m_sent[k];
        c[0] = m_sent[0] ^ 20'h12345;
        fb = a_frames;
        drive_stream(4'b0001, c);
        repeat (10) @(posedge a_clk);
        check("stream_held_in_cfg_mode", a_frames, fb);
        pulse_send();
        wait_idle("idle_after_cfg");
        check("one_cfg_frame", a_frames, fb + 1);
        set_mode(1'b0);
        wait_idle("idle_after_mode_exit");
        write_cfg(0, 32'hABCDEF);
        fb = a_frames;
        pulse_send();
        wait_idle("idle_after_ignored_send");
        check("send_ignored_outside_cfg", a_frames, fb);
        set_mode(1'b1);
        pulse_send();
        wait_idle("idle_after_second_cfg");
        set_mode(1'b0);

        // Mid-frame update on lane 1, followed by a back-to-back frame.
        for (int k = 0; k < NA; k++) c[k] = m_latch[k];
        c[1] = m_sent[1] ^ 20'h5A5A5;
        drive_stream(4'b0010, c);
        repeat (30) @(posedge a_clk);
        check("busy_mid_frame", a_busy, 1'b1);
        c[1] = c[1] ^ 20'h00001;
        check_gap = 1'b1;
        drive_stream(4'b0010, c);
        wait_idle("idle_after_b2b");

        // Reset at the 10th SCLK fall of a frame.
        c[2] = m_sent[2] ^ 20'hFFFFF;
        drive_stream(4'b0100, c);
        nf = 0;
        n  = 0;
        ps = a_sclk;
        while (nf < 10 && n < 1000) begin
            @(negedge a_clk);
            if (ps && !a_sclk) nf++;
            ps = a_sclk;
            n++;
        end
        check("reached_10th_fall", nf, 10);
        reset = 1'b1;
        @(negedge a_clk);
        check("abort_sync_n", a_sync_n, 1'b1);
        check("abort_sclk", a_sclk, 1'b0);
        check("abort_busy", a_busy, 1'b0);
        check("abort_frames", a_frames, 32'd0);
        model_reset();
        @(posedge a_clk); #1;
        reset = 1'b0;
        c[0] = DB'($urandom) | 20'h1;
        drive_stream(4'b0001, c);
        wait_idle("idle_after_recovery");
        check("frames_after_recovery", a_frames, 32'd1);

        // Eight lanes at SCLK_HALF=1, each with its own code.
        @(posedge a_clk); #1;
        for (int k = 0; k < NB; k++) begin
            logic [DB-1:0] bc;
            bc = {k[2:0], 17'($urandom)} | 20'h1;
            b_tdata[32*k +: 32] = {bc, 12'($urandom)};
            bf[k*FB +: FB] = {4'b0001, bc};
        end
        b_tvalid = '1;
        exp_qb.push_back(bf);
        @(posedge a_clk); #1;
        b_tvalid = '0;
        n = 0;
        while (exp_qb.size() != 0 && n < 500) begin
            @(negedge a_clk);
            n++;
        end
        repeat (8) @(posedge a_clk);
        check("b_frames_sent", b_frames, 32'd1);

        check("scoreboard_a_drained", exp_q.size(), 0);
        check("scoreboard_b_drained", exp_qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
